// File: rtl/mcu_seq_ctrl.sv
// Frame sequencer that paces MCU bank changes for a column-streaming convolver.
// Optional frame abort path (i_abort/o_abort) is enabled by defining MCU_SEQ_CTRL_ABORT_EN.
module mcu_seq_ctrl #(
    parameter int unsigned N     = 2,
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [COL_W-1:0] i_ncols,
    input  logic [ROW_W-1:0] i_nrows,
    input  logic             i_col_valid,
    input  logic             i_conv_ready,
    output logic             o_chblk,
    output logic             o_sop,
    output logic             o_eop,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [COL_W-1:0] o_col_cnt,
    output logic [ROW_W-1:0] o_row_blk
`ifdef MCU_SEQ_CTRL_ABORT_EN
    ,
    input  logic             i_abort,
    output logic             o_abort
`endif
);

    localparam int unsigned      FlushW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [COL_W-1:0] LoadCols  = COL_W'(N + 1);
    localparam logic [COL_W-1:0] MinCols   = COL_W'(N + 2);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StFlush,
        StDone
    } state_e;

    state_e            state_q;
    logic [COL_W-1:0]  ncols_q;
    logic [ROW_W-1:0]  nrows_q;
    logic [COL_W-1:0]  col_cnt_q;
    logic [ROW_W-1:0]  row_blk_q;
    logic [FlushW-1:0] flush_cnt_q;
    logic [COL_W-1:0]  chblk_pend_q;
    logic              sop_q;
    logic              eop_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              chblk_q;

    logic              abort_hit;
    logic              start_ok;
    logic              col_acc;
    logic              conv_acc;
    logic              last_row;
    logic [COL_W-1:0]  col_cnt_inc;
    logic [COL_W:0]    chblk_want;

`ifdef MCU_SEQ_CTRL_ABORT_EN
    logic abort_q;
    assign abort_hit = i_abort && (state_q != StIdle);
    assign o_abort   = abort_q;
`else
    assign abort_hit = 1'b0;
`endif

    assign start_ok    = (i_ncols >= MinCols) && (i_nrows != '0);
    assign col_acc     = i_col_valid && !abort_hit && ((state_q == StLoad) || (state_q == StRun));
    assign conv_acc    = i_conv_ready && !abort_hit && (state_q == StFlush);
    assign last_row    = (row_blk_q == (nrows_q - ROW_W'(1)));
    assign col_cnt_inc = col_cnt_q + COL_W'(1);
    // Requests that arrive while a pulse is out are queued so o_chblk always has a gap cycle.
    assign chblk_want  = {1'b0, chblk_pend_q} + {{COL_W{1'b0}}, (col_acc || conv_acc)};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            ncols_q      <= '0;
            nrows_q      <= '0;
            col_cnt_q    <= '0;
            row_blk_q    <= '0;
            flush_cnt_q  <= '0;
            chblk_pend_q <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            chblk_q      <= 1'b0;
`ifdef MCU_SEQ_CTRL_ABORT_EN
            abort_q      <= 1'b0;
`endif
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef MCU_SEQ_CTRL_ABORT_EN
            abort_q <= 1'b0;
`endif
            if (abort_hit) begin
                chblk_q      <= 1'b0;
                chblk_pend_q <= '0;
            end else if (!chblk_q && (chblk_want != '0)) begin
                chblk_q      <= 1'b1;
                chblk_pend_q <= COL_W'(chblk_want - (COL_W + 1)'(1));
            end else begin
                chblk_q      <= 1'b0;
                chblk_pend_q <= COL_W'(chblk_want);
            end

            if (abort_hit) begin
                state_q     <= StIdle;
                col_cnt_q   <= '0;
                row_blk_q   <= '0;
                flush_cnt_q <= '0;
                sop_q       <= 1'b0;
                eop_q       <= 1'b0;
                busy_q      <= 1'b0;
`ifdef MCU_SEQ_CTRL_ABORT_EN
                abort_q     <= 1'b1;
`endif
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (i_start) begin
                            if (start_ok) begin
                                ncols_q     <= i_ncols;
                                nrows_q     <= i_nrows;
                                col_cnt_q   <= '0;
                                row_blk_q   <= '0;
                                flush_cnt_q <= '0;
                                busy_q      <= 1'b1;
                                state_q     <= StLoad;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    StLoad: begin
                        if (col_acc) begin
                            col_cnt_q <= col_cnt_inc;
                            if (col_cnt_inc == LoadCols) begin
                                sop_q   <= 1'b1;
                                state_q <= StRun;
                            end
                        end
                    end
                    StRun: begin
                        if (col_acc) begin
                            col_cnt_q <= col_cnt_inc;
                            if (col_cnt_inc == ncols_q) begin
                                sop_q       <= 1'b0;
                                eop_q       <= 1'b1;
                                flush_cnt_q <= '0;
                                state_q     <= StFlush;
                            end
                        end
                    end
                    StFlush: begin
                        if (conv_acc) begin
                            if (flush_cnt_q == FlushLast) begin
                                eop_q       <= 1'b0;
                                flush_cnt_q <= '0;
                                if (last_row) begin
                                    done_q  <= 1'b1;
                                    state_q <= StDone;
                                end else begin
                                    row_blk_q <= row_blk_q + ROW_W'(1);
                                    col_cnt_q <= '0;
                                    state_q   <= StLoad;
                                end
                            end else begin
                                flush_cnt_q <= flush_cnt_q + FlushW'(1);
                            end
                        end
                    end
                    StDone: begin
                        busy_q    <= 1'b0;
                        col_cnt_q <= '0;
                        row_blk_q <= '0;
                        state_q   <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_chblk   = chblk_q;
    assign o_sop     = sop_q;
    assign o_eop     = eop_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_col_cnt = col_cnt_q;
    assign o_row_blk = row_blk_q;

endmodule
